paddle_controller: RTL and testbench
====================================

Name: paddle_controller

Overview:
Per-frame paddle motion controller. Converts player buttons into the paddle centre x-coordinate consumed by the paddle drawer. Updates once per video frame on frame_tick, with an accelerate-on-hold state machine and screen-edge clamping. x is held constant for a whole frame so the drawn paddle never tears.

Parameters:
SCREEN_WIDTH, 640, visible width in pixels.
PADDLE_WIDTH, 99, paddle width in pixels (odd); must match the drawer.
X_INIT, 320, centre x after reset or recentre.
SPEED_SLOW, 2, pixels per frame while in SLOW.
SPEED_FAST, 6, pixels per frame while in FAST.
ACCEL_FRAMES, 8, number of consecutive SLOW moves before entering FAST (1..255).
AUTO_DEADBAND, 4, autoplay deadband in pixels (optional feature only).

Ports:
clk  in  1  system/pixel clock.
reset  in  1  asynchronous, active-high reset.
frame_tick  in  1  one-cycle pulse per frame, issued in vblank.
btn_left  in  1  asynchronous button, high = pressed.
btn_right  in  1  asynchronous button, high = pressed.
recenter  in  1  synchronous one-cycle request: return paddle to X_INIT.
autoplay  in  1  autoplay enable (optional feature only; otherwise ignored).
ball_x  in  10  ball centre x (optional feature only; otherwise ignored).
x  out  10  paddle centre x, registered.
moving  out  1  high when state != IDLE.
fast  out  1  high when state == FAST.
at_edge  out  1  high when the last update was clamped.

Behaviour:
- Reset (async, active-high): x=X_INIT, state=IDLE, hold_cnt=0, moving=0, fast=0, at_edge=0, both synchronizer stages=0. Reset asserted mid-frame or mid-motion takes effect immediately.
- Each button passes through a 2-flop synchronizer. Only the synchronized value in the frame_tick cycle matters. Activity between ticks is ignored.
- Direction decode at a tick: left only = -1; right only = +1; both or neither = 0.
- States are IDLE, SLOW and FAST. hold_cnt is 8 bits. Transitions are evaluated only on frame_tick:
  - dir=0 (any state): go to IDLE, hold_cnt=0, no move.
  - dir!=0 from IDLE, or dir opposite to the stored direction: go to SLOW, hold_cnt=1, store dir.
  - SLOW with same dir: if hold_cnt==ACCEL_FRAMES go to FAST, else hold_cnt+1.
  - FAST with same dir: stay in FAST.
- Step size is SPEED_SLOW or SPEED_FAST according to the NEW state. The first tick of a press is therefore a slow move. Ticks 1..ACCEL_FRAMES of a continuous hold are slow; later ticks are fast.
- Position arithmetic is signed 12-bit: xn = x + dir*step.
- Clamp limits: X_MIN = PADDLE_WIDTH/2 (49); X_MAX = SCREEN_WIDTH - (PADDLE_WIDTH+1)/2 (590).
  - xn < X_MIN gives x=X_MIN and at_edge=1.
  - xn > X_MAX gives x=X_MAX and at_edge=1.
  - Otherwise x=xn and at_edge=0.
- Holding against an edge keeps the state and counter advancing. x stays pinned and at_edge stays 1.
- At a tick with dir=0, at_edge is cleared.
- Latency: x, moving, fast and at_edge update on the clock edge that samples frame_tick. They are valid from the next cycle and hold until the next tick.
- recenter: x=X_INIT, state=IDLE, hold_cnt=0, at_edge=0.
  - If recenter coincides with frame_tick, recenter wins and that tick is discarded (no move).
- Back-to-back frame_tick on consecutive cycles: each is processed independently.

Optional Feature:
PADDLE_AUTOPLAY_EN. When defined and autoplay=1, dir comes from ball_x instead of the buttons:
- ball_x + AUTO_DEADBAND < x gives -1.
- ball_x > x + AUTO_DEADBAND gives +1.
- Otherwise 0.
State machine, speeds and clamping are unchanged. The comparison uses 11-bit unsigned values.
When the macro is undefined, autoplay and ball_x are present but unused, and dir always comes from the buttons.

Test Plan:
- Reset then 3 ticks with no buttons -> x=320, moving=0, fast=0, at_edge=0 throughout.
- Hold btn_right for 10 ticks (defaults) -> x after each tick: 322, 324, ... 336 (ticks 1-8, fast=0), then 342, 348 (fast=1).
- After reaching FAST rightward, press left only -> next tick x decreases by 2, fast=0, hold_cnt restarted; both buttons pressed -> no move, moving=0.
- Hold btn_left for 60 ticks -> x decreases monotonically, reaches 49 and stays there, at_edge=1, never below 49; release -> at_edge=0 at the next tick.
- Hold right until x=348, then assert recenter in the same cycle as frame_tick -> x=320, state IDLE; assert reset asynchronously mid-hold -> x=320 without a clock edge.
- With PADDLE_AUTOPLAY_EN, autoplay=1, ball_x=400, x=320, buttons held left -> x increases by 2 per tick; ball_x=322 at x=320 -> no move (inside deadband).

Source files
------------

// File: rtl/paddle_controller.sv
// Per-frame paddle motion controller: synchronised buttons drive an IDLE/SLOW/FAST
// state machine that moves a clamped paddle centre once per frame_tick. Optional: PADDLE_AUTOPLAY_EN.
module paddle_controller #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int PADDLE_WIDTH  = 99,
  parameter int X_INIT        = 320,
  parameter int SPEED_SLOW    = 2,
  parameter int SPEED_FAST    = 6,
  parameter int ACCEL_FRAMES  = 8,
  parameter int AUTO_DEADBAND = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       recenter,
  input  logic       autoplay,
  input  logic [9:0] ball_x,
  output logic [9:0] x,
  output logic       moving,
  output logic       fast,
  output logic       at_edge
);

  localparam logic signed [11:0] X_MIN = 12'(PADDLE_WIDTH / 2);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_WIDTH - (PADDLE_WIDTH + 1) / 2);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        right_q, right_d;
  logic [9:0]  x_q, x_d;
  logic        edge_q, edge_d;
  logic        moving_q, fast_q;
  logic [1:0]  lsync_q, rsync_q;

  logic              want_l, want_r;
  logic signed [11:0] step, xn;

`ifdef PADDLE_AUTOPLAY_EN
  logic [10:0] ball_w, x_w;
  assign ball_w = {1'b0, ball_x};
  assign x_w    = {1'b0, x_q};
  always_comb begin
    want_l = lsync_q[1];
    want_r = rsync_q[1];
    if (autoplay) begin
      want_l = (ball_w + 11'(AUTO_DEADBAND)) < x_w;
      want_r = ball_w > (x_w + 11'(AUTO_DEADBAND));
    end
  end
`else
  logic unused_autoplay;
  assign unused_autoplay = ^{autoplay, ball_x};
  assign want_l = lsync_q[1];
  assign want_r = rsync_q[1];
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    x_d     = x_q;
    edge_d  = edge_q;
    step    = '0;
    xn      = signed'({2'b00, x_q});
    if (recenter) begin
      // Recenter wins over a coincident tick; that tick is dropped.
      state_d = IDLE;
      cnt_d   = '0;
      x_d     = 10'(X_INIT);
      edge_d  = 1'b0;
    end else if (frame_tick) begin
      if (want_l == want_r) begin
        state_d = IDLE;
        cnt_d   = '0;
        edge_d  = 1'b0;
      end else begin
        if (state_q == IDLE || want_r != right_q) begin
          state_d = SLOW;
          cnt_d   = 8'd1;
          right_d = want_r;
        end else if (state_q == SLOW) begin
          if (cnt_q == 8'(ACCEL_FRAMES)) state_d = FAST;
          else                           cnt_d   = cnt_q + 8'd1;
        end
        step = (state_d == FAST) ? 12'(SPEED_FAST) : 12'(SPEED_SLOW);
        xn   = want_r ? xn + step : xn - step;
        if (xn < X_MIN) begin
          x_d    = 10'(X_MIN);
          edge_d = 1'b1;
        end else if (xn > X_MAX) begin
          x_d    = 10'(X_MAX);
          edge_d = 1'b1;
        end else begin
          x_d    = xn[9:0];
          edge_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lsync_q  <= '0;
      rsync_q  <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      right_q  <= 1'b0;
      x_q      <= 10'(X_INIT);
      edge_q   <= 1'b0;
      moving_q <= 1'b0;
      fast_q   <= 1'b0;
    end else begin
      lsync_q  <= {lsync_q[0], btn_left};
      rsync_q  <= {rsync_q[0], btn_right};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      right_q  <= right_d;
      x_q      <= x_d;
      edge_q   <= edge_d;
      moving_q <= (state_d != IDLE);
      fast_q   <= (state_d == FAST);
    end
  end

  assign x       = x_q;
  assign moving  = moving_q;
  assign fast    = fast_q;
  assign at_edge = edge_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Randomised self-checking bench for paddle_controller against a press-length
// based reference model of paddle motion.
module tb_paddle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       recenter = 1'b0;
  logic       autoplay = 1'b0;
  logic [9:0] ball_x = '0;
  logic [9:0] x;
  logic       moving, fast, at_edge;

  paddle_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .recenter(recenter),
    .autoplay(autoplay), .ball_x(ball_x),
    .x(x), .moving(moving), .fast(fast), .at_edge(at_edge)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position, length of the current uninterrupted press, its direction.
  int x_m    = 320;
  int len_m  = 0;
  int dir_m  = 0;
  bit edge_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tick_dir();
    int d;
    d = (btn_left && !btn_right) ? -1 : (btn_right && !btn_left) ? 1 : 0;
`ifdef PADDLE_AUTOPLAY_EN
    if (autoplay) d = (ball_x + 4 < x_m) ? -1 : (ball_x > x_m + 4) ? 1 : 0;
`endif
    return d;
  endfunction

  task automatic model_reset();
    x_m = 320; len_m = 0; dir_m = 0; edge_m = 1'b0;
  endtask

  task automatic model_tick(input int d);
    int xn;
    if (d == 0) begin
      len_m = 0;
      edge_m = 1'b0;
    end else begin
      len_m = (len_m == 0 || d != dir_m) ? 1 : len_m + 1;
      dir_m = d;
      xn = x_m + d * ((len_m <= 8) ? 2 : 6);
      edge_m = (xn < 49) || (xn > 590);
      x_m = (xn < 49) ? 49 : (xn > 590) ? 590 : xn;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".x"}, 32'(x), 32'(x_m));
    check({tag, ".moving"}, 32'(moving), 32'(len_m > 0));
    check({tag, ".fast"}, 32'(fast), 32'(len_m > 8));
    check({tag, ".at_edge"}, 32'(at_edge), 32'(edge_m));
  endtask

  // Buttons change on a falling edge and settle through the synchroniser before the next tick.
  task automatic press(input bit l, input bit r);
    @(negedge clk);
    btn_left = l;
    btn_right = r;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_tick(input bit rc, input bit tk, input string tag);
    int d;
    @(negedge clk);
    d = tick_dir();
    frame_tick = tk;
    recenter = rc;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    recenter = 1'b0;
    if (rc) model_reset();
    else if (tk) model_tick(d);
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) do_tick(0, 1, "idle");

    press(0, 1);
    for (int i = 0; i < 10; i++) begin
      do_tick(0, 1, "ramp");
      check("ramp_x_const", 32'(x), (i < 8) ? 32'(322 + 2 * i) : 32'(342 + 6 * (i - 8)));
      check("ramp_fast_const", 32'(fast), 32'(i >= 8));
    end

    press(1, 0);
    do_tick(0, 1, "reverse");
    check("reverse_x_const", 32'(x), 32'd346);
    press(1, 1);
    do_tick(0, 1, "both");
    check("both_moving_const", 32'(moving), 32'd0);

    press(1, 0);
    for (int i = 0; i < 60; i++) do_tick(0, 1, "left_hold");
    check("left_pin_const", 32'(x), 32'd49);
    check("left_edge_const", 32'(at_edge), 32'd1);
    press(0, 0);
    do_tick(0, 1, "release");

    do_tick(1, 0, "recenter_only");
    press(0, 1);
    for (int i = 0; i < 10; i++) do_tick(0, 1, "to348");
    check("to348_const", 32'(x), 32'd348);
    do_tick(1, 1, "recenter_tick");
    check("recenter_x_const", 32'(x), 32'd320);
    do_tick(0, 1, "after_recenter");
    do_tick(0, 1, "b2b_a");
    do_tick(0, 1, "b2b_b");
    async_reset("async_reset");
    press(0, 1);
    do_tick(0, 1, "post_reset");

    for (int i = 0; i < 400; i++) begin
      int pick;
      // Glitch the buttons between ticks; only the settled value at the tick matters.
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        @(negedge clk);
        btn_left = 1'($urandom);
        btn_right = 1'($urandom);
      end
      autoplay = 1'($urandom);
      ball_x = 10'($urandom_range(0, 639));
      pick = $urandom_range(0, 9);
      if (pick < 3) press(1, 0);
      else if (pick < 6) press(0, 1);
      else if (pick < 8) press(btn_left, btn_right);
      else press(1'($urandom), 1'($urandom));
      pick = $urandom_range(0, 99);
      if (pick < 4) do_tick(1, 1'($urandom), "rand_recenter");
      else if (pick < 6) async_reset("rand_reset");
      else if (pick < 12) begin
        do_tick(0, 1, "rand_b2b_a");
        do_tick(0, 1, "rand_b2b_b");
      end else do_tick(0, 1, "rand_tick");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
